// File: rtl/piso_stream_if.sv
// Handshake bundle for piso_stream. The parallel producer side and the serial consumer side
// are carried together; the slave modport is the serialiser's view.
interface piso_stream_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 1,
    parameter int unsigned CNT_W = 16
);
    logic [WIDTH-1:0] data_i;
    logic             valid_in;
    logic             ready_out;
    logic [LANES-1:0] data_o;
    logic             valid_out;
    logic             ready_in;
    logic             last_o;
    logic [CNT_W-1:0] frame_cnt_o;

    modport master (
        output data_i, valid_in, ready_in,
        input  ready_out, data_o, valid_out, last_o, frame_cnt_o
    );

    modport slave (
        input  data_i, valid_in, ready_in,
        output ready_out, data_o, valid_out, last_o, frame_cnt_o
    );
endinterface

// File: rtl/piso_stream.sv
// Parallel-in/serial-out serialiser with a one-word holding buffer, LANES bits per beat,
// selectable lane order, downstream backpressure and a wrapping completed-word counter.
module piso_stream #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned LANES     = 1,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input logic          clk_in,
    input logic          rst,
    piso_stream_if.slave bus
);
    localparam int unsigned BEATS = (LANES == 0) ? 1 : WIDTH / LANES;
    localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (LANES < 1 || WIDTH < 1 || (WIDTH % LANES) != 0) begin : g_bad_cfg
        $error("piso_stream: WIDTH must be a nonzero multiple of LANES");
    end

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic             ready_c;
    logic             last_c;
    logic             advance_c;
    logic [LANES-1:0] beat_c;

    // State register; reset discards both the in-flight and the held word.
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            sreg_q       <= '0;
            cnt_q        <= '0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            sreg_q       <= sreg_d;
            cnt_q        <= cnt_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    // Next-state: beat advance, then shifter reload from hold, then input accept.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        sreg_d       = sreg_q;
        cnt_d        = cnt_q;
        frame_cnt_d  = frame_cnt_q;
        beat_c       = '0;

        ready_c   = rst && !hold_valid_q;
        last_c    = (state_q == ST_BUSY) && (cnt_q == CW'(BEATS - 1));
        advance_c = (state_q == ST_BUSY) && bus.ready_in;

        if (state_q == ST_BUSY) begin
            beat_c = MSB_FIRST ? sreg_q[WIDTH-1 -: LANES] : sreg_q[LANES-1:0];
        end

        if (advance_c) begin
            sreg_d = MSB_FIRST ? (sreg_q << LANES) : (sreg_q >> LANES);
            if (last_c) begin
                cnt_d       = '0;
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
                state_d     = ST_IDLE;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // Reload on the last-beat edge keeps the stream gap-free across words.
        if (hold_valid_q && ((state_q == ST_IDLE) || (advance_c && last_c))) begin
            sreg_d       = hold_q;
            cnt_d        = '0;
            state_d      = ST_BUSY;
            hold_valid_d = 1'b0;
        end

        // Never coincides with a reload: ready_c is low whenever hold is occupied.
        if (bus.valid_in && ready_c) begin
            hold_d       = bus.data_i;
            hold_valid_d = 1'b1;
        end
    end

    assign bus.ready_out   = ready_c;
    assign bus.valid_out   = (state_q == ST_BUSY);
    assign bus.last_o      = last_c;
    assign bus.data_o      = beat_c;
    assign bus.frame_cnt_o = frame_cnt_q;

endmodule

// File: doc/piso_stream.md
Name: piso_stream

Overview:
- Parametrised parallel-in/serial-out serialiser with valid/ready handshakes on both sides. Single clock.
- Successor to the basic 4-bit PISO. Adds:
  - configurable word width and lanes per beat (1..WIDTH bits per serial beat);
  - MSB-first or LSB-first ordering;
  - a one-word holding buffer for gap-free back-to-back words;
  - downstream backpressure, a last-beat marker and a completed-word counter.
- Sits between a parallel producer and a narrow serial link/consumer.

Parameters:
- WIDTH, 8, parallel word width in bits. Must be >= 1.
- LANES, 1, bits emitted per serial beat. WIDTH % LANES must be 0, else elaboration error.
- MSB_FIRST, 1, 1 = most-significant lane first; 0 = least-significant lane first.
- CNT_W, 16, width of the completed-word counter.

Ports:
- clk_in  input  1  clock; all logic on posedge.
- rst  input  1  synchronous reset, active-low. Sampled on posedge clk_in.
- data_i  input  WIDTH  parallel word from producer.
- valid_in  input  1  producer has a word on data_i.
- ready_out  output  1  block can accept a word this cycle.
- data_o  output  LANES  current serial beat.
- valid_out  output  1  data_o holds a valid beat.
- ready_in  input  1  consumer accepts the beat this cycle.
- last_o  output  1  current beat is the final beat of its word.
- frame_cnt_o  output  CNT_W  count of fully transmitted words; wraps.

Behaviour:
- BEATS = WIDTH/LANES.
- State: hold (WIDTH), hold_valid, sreg (WIDTH), busy, beat counter cnt (0..BEATS-1), frame_cnt.
- Reset (rst=0 at posedge):
  - hold, sreg, cnt, frame_cnt cleared to 0; hold_valid = 0; busy = 0.
  - Outputs: valid_out = 0, last_o = 0, data_o = 0, frame_cnt_o = 0.
  - ready_out = 0 while rst is low (combinational gate), so no word is accepted during reset.
- Reset mid-word: the in-flight word and any held word are discarded; no partial beats after reset.
- ready_out = rst && !hold_valid (combinational).
- Input accept when valid_in && ready_out at posedge: hold <= data_i, hold_valid <= 1.
- Shifter load when hold_valid && (!busy || beat_done):
  - beat_done = valid_out && ready_in && last_o.
  - Effect: sreg <= hold, busy <= 1, cnt <= 0, hold_valid <= 0.
  - A load and an accept never collide in one cycle, because ready_out = 0 whenever hold_valid = 1.
- Latency: word accepted at edge N has its first beat valid after edge N+1.
- Output (combinational from regs):
  - valid_out = busy.
  - last_o = busy && cnt == BEATS-1.
  - MSB_FIRST=1: data_o = sreg[WIDTH-1 -: LANES]. MSB_FIRST=0: data_o = sreg[LANES-1:0].
  - data_o = 0 when !busy.
- Beat advance only on valid_out && ready_in:
  - MSB_FIRST=1: sreg shifts left by LANES. MSB_FIRST=0: sreg shifts right by LANES.
  - cnt increments.
- On last beat advance:
  - frame_cnt increments (modulo 2^CNT_W).
  - If hold_valid, load the next word the same edge (no bubble). Otherwise busy <= 0.
- Backpressure: while ready_in = 0, data_o, last_o, cnt and sreg hold stable; valid_out stays 1.
- Throughput: with ready_in held high and the producer keeping hold full, valid_out stays continuously high across word boundaries.
- LANES == WIDTH: BEATS = 1, every beat has last_o = 1.

Test Plan:
- WIDTH=8, LANES=1, MSB_FIRST=1, ready_in=1; send 0xB4 once.
  - Response: data_o = 1,0,1,1,0,1,0,0 on 8 consecutive valid cycles starting 1 cycle after accept.
  - last_o high only on the 8th beat; frame_cnt_o = 1 afterwards; valid_out = 0 after.
- Same config; producer presents 0xA5 then 0x3C back-to-back.
  - Response: 16 consecutive valid beats (10100101 then 00111100) with no gap.
  - ready_out drops to 0 while hold is full; frame_cnt_o = 2.
- Backpressure: send 0xB4, drop ready_in for 4 cycles after the 3rd beat is accepted.
  - Response: data_o holds 1 (4th bit) with valid_out = 1 and last_o = 0 throughout; the stream resumes correctly.
- WIDTH=8, LANES=2, MSB_FIRST=0; send 0xB4.
  - Response: beats 2'b00, 2'b01, 2'b11, 2'b10; last_o on the 4th beat.
- Reset mid-word: rst=0 for one cycle after the 3rd beat of 0xFF, with 0x0F in hold.
  - Response: next cycle valid_out = 0, data_o = 0, frame_cnt_o = 0, ready_out = 1.
  - No further beats until a new word is sent.
- CNT_W=2: send 5 words.
  - Response: frame_cnt_o sequence 1,2,3,0,1.
